// File: rtl/m68k_bus_arbiter.sv
// 68000 bus mastership arbiter between the Pi transaction engine and external DMA masters.
// Runs in the PI_CLK domain; every state change happens on a synchronized M68K_CLK falling edge.
module m68k_bus_arbiter #(
  parameter int SYNC_STAGES = 2,
  parameter int BG_TIMEOUT  = 16,
  parameter int REARB_GAP   = 4
) (
  input  logic i_pi_clk,
  input  logic i_pi_rst_n,
  input  logic i_m68k_clk,
  input  logic i_m68k_br_n,
  input  logic i_m68k_bgack_n,
  input  logic i_pi_req,
  input  logic i_cyc_active,
  output logic o_pi_grant,
  output logic o_drv_en,
  output logic o_m68k_bg_n,
  output logic o_ext_owned,
  output logic o_arb_timeout
);
  localparam int TO_W  = $clog2(BG_TIMEOUT) + 1;
  localparam int GAP_W = $clog2(REARB_GAP) + 1;

  typedef enum logic [1:0] {PI_OWN, ARB_WAIT, GRANT, EXT} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_br_sync, r_bgack_sync;
  logic [SYNC_STAGES:0]   r_clk_sync;
  logic [TO_W-1:0]        r_to_cnt;
  logic [GAP_W-1:0]       r_gap_cnt;
  logic                   r_pi_grant, r_drv_en, r_bg_n, r_ext_owned, r_arb_timeout;
  logic                   w_br, w_bgack, w_tick;

  always_ff @(posedge i_pi_clk or negedge i_pi_rst_n) begin
    if (!i_pi_rst_n) begin
      r_br_sync    <= '1;
      r_bgack_sync <= '1;
      r_clk_sync   <= '0;
    end else begin
      r_br_sync    <= {r_br_sync[SYNC_STAGES-2:0], i_m68k_br_n};
      r_bgack_sync <= {r_bgack_sync[SYNC_STAGES-2:0], i_m68k_bgack_n};
      r_clk_sync   <= {r_clk_sync[SYNC_STAGES-1:0], i_m68k_clk};
    end
  end

  assign w_br    = ~r_br_sync[SYNC_STAGES-1];
  assign w_bgack = ~r_bgack_sync[SYNC_STAGES-1];
  // Extra clock stage gives the previous sample for falling-edge detection.
  assign w_tick  = r_clk_sync[SYNC_STAGES] & ~r_clk_sync[SYNC_STAGES-1];

  always_ff @(posedge i_pi_clk or negedge i_pi_rst_n) begin
    if (!i_pi_rst_n) begin
      r_state       <= PI_OWN;
      r_pi_grant    <= 1'b1;
      r_drv_en      <= 1'b1;
      r_bg_n        <= 1'b1;
      r_ext_owned   <= 1'b0;
      r_arb_timeout <= 1'b0;
      r_to_cnt      <= '0;
      r_gap_cnt     <= '0;
    end else begin
      r_arb_timeout <= 1'b0;
      if (w_tick) begin
        if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 1'b1;
        case (r_state)
          PI_OWN, ARB_WAIT: begin
            // A master that grabbed the bus unasked is adopted only at a cycle boundary.
            if (w_bgack) begin
              if (!i_cyc_active) begin
                r_state     <= EXT;
                r_pi_grant  <= 1'b0;
                r_drv_en    <= 1'b0;
                r_ext_owned <= 1'b1;
              end
            end else if (r_state == PI_OWN) begin
              if (w_br && r_gap_cnt == '0) begin
                r_state    <= ARB_WAIT;
                r_pi_grant <= 1'b0;
              end
            end else if (!w_br) begin
              r_state    <= PI_OWN;
              r_pi_grant <= 1'b1;
            end else if (!i_cyc_active) begin
              r_state  <= GRANT;
              r_bg_n   <= 1'b0;
              r_to_cnt <= '0;
            end
          end
          GRANT: begin
            r_to_cnt <= r_to_cnt + 1'b1;
            if (w_bgack) begin
              r_state     <= EXT;
              r_bg_n      <= 1'b1;
              r_drv_en    <= 1'b0;
              r_ext_owned <= 1'b1;
            end else if (!w_br) begin
              r_state    <= PI_OWN;
              r_bg_n     <= 1'b1;
              r_pi_grant <= 1'b1;
            end else if (r_to_cnt == TO_W'(BG_TIMEOUT - 1)) begin
              r_state       <= PI_OWN;
              r_bg_n        <= 1'b1;
              r_pi_grant    <= 1'b1;
              r_arb_timeout <= 1'b1;
              r_gap_cnt     <= GAP_W'(REARB_GAP);
            end
          end
          EXT: begin
            if (!w_bgack) begin
              r_state     <= PI_OWN;
              r_drv_en    <= 1'b1;
              r_pi_grant  <= 1'b1;
              r_ext_owned <= 1'b0;
              r_gap_cnt   <= GAP_W'(REARB_GAP);
            end
          end
          default: r_state <= PI_OWN;
        endcase
      end
    end
  end

  assign o_pi_grant    = r_pi_grant;
  assign o_drv_en      = r_drv_en;
  assign o_m68k_bg_n   = r_bg_n;
  assign o_ext_owned   = r_ext_owned;
  assign o_arb_timeout = r_arb_timeout;
endmodule
